arrow_lane_engine: RTL and testbench
====================================

# arrow_lane_engine

Parametrised arrow playfield for the DDR display pipeline. It holds up to SLOTS live arrows in each of LANES lanes and accepts new arrows from the chart sequencer over a valid/ready handshake. Once per video frame it scrolls every arrow upward toward the target line, and it judges button presses as hits or misses. On each pixel it produces a registered per-lane coverage mask for the colour mixer.

## Interface
Parameters:
- CORDW, 10: screen coordinate width.
- LANES, 4: number of arrow lanes (≥1).
- SLOTS, 4: arrow slots per lane (≥1).
- ARROWX_BEGIN, 0: x of the lane 0 left edge.
- LANE_PITCH, 40: x spacing between lanes. Lane l left edge = ARROWX_BEGIN + l*LANE_PITCH.
- ARROW_SIZE, 5: arrow square extent. Inclusive, so an arrow spans ARROW_SIZE+1 pixels.
- SPAWN_Y, 470: y given to a newly spawned arrow.
- TARGET_Y, 30: y of the target line.
- HIT_WIN, 6: hit tolerance, ±pixels around TARGET_Y. Requires HIT_WIN ≤ TARGET_Y.
- SPEED, 2: pixels moved per frame.

Ports:
- clk_i, in, 1: pixel clock.
- rst_ni, in, 1: asynchronous, active-low reset.
- frame_i, in, 1: one-cycle pulse once per frame, issued during blanking.
- sx_i, in, CORDW: current pixel x.
- sy_i, in, CORDW: current pixel y.
- spawn_valid_i, in, 1: spawn request.
- spawn_lane_i, in, $clog2(LANES) (min 1): lane to spawn into.
- spawn_ready_o, out, 1: spawn accepted this cycle when high together with valid.
- btn_i, in, LANES: one-cycle press pulses, already debounced and edge-detected. Bit l is lane l.
- hit_o, out, LANES: one-cycle hit pulse per lane.
- miss_o, out, LANES: one-cycle miss pulse per lane.
- arrow_o, out, LANES: registered coverage mask. Bit l is lane l.

## Operation
- Slot state: a valid bit plus a y value (CORDW bits) for each of LANES×SLOTS slots.
- Reset:
  - All slots are invalid with y = 0.
  - hit_o, miss_o and arrow_o are 0.
  - Reset is asynchronous and takes effect mid-frame. Pending pulses drop immediately.
- Spawn:
  - spawn_ready_o is combinational: 1 iff spawn_lane_i < LANES and that lane has at least one invalid slot.
  - On valid && ready, the lowest-index free slot of the lane becomes valid with y = SPAWN_Y.
  - Holding valid while ready is low is legal. The request waits.
- Scroll (frame_i cycle):
  - Every valid slot takes new_y = y − SPEED, clamped to 0 if y < SPEED.
  - If new_y + HIT_WIN < TARGET_Y (computed in CORDW+1 bits), the slot is cleared and that lane's miss pulse is set. Multiple misses in one lane in the same frame give a single pulse.
- Judge (btn_i[l] cycle):
  - Candidates are valid slots of lane l with TARGET_Y − HIT_WIN ≤ y ≤ TARGET_Y + HIT_WIN, using the current (pre-scroll) y.
  - The winner is the candidate with the lowest y; ties go to the lowest slot index.
  - The winner is cleared and hit_o[l] pulses.
  - With no candidate, nothing happens. There is no miss for a stray press.
- Simultaneous events in one cycle:
  - The judge is evaluated first, on pre-scroll state. A slot cleared by a hit is neither scrolled nor missed.
  - A slot spawned this cycle is not scrolled this frame.
  - Spawn uses the free-slot view before this cycle's clears. A slot freed by a hit or miss is available only next cycle.
  - hit_o[l] and miss_o[l] may both pulse in the same cycle.
- Draw: the arrow_o[l] register takes 1 iff some valid slot s of lane l has:
  - lane_x ≤ sx_i ≤ lane_x + ARROW_SIZE, and
  - y_s ≤ sy_i ≤ y_s + ARROW_SIZE.
  - Coverage is evaluated on the pre-update slot state. Additions use CORDW+1 bits, so there is no wrap.

## Timing
- arrow_o: 1-cycle latency from sx_i/sy_i.
- hit_o and miss_o: registered, asserted the cycle after the btn_i or frame_i cycle, high for exactly 1 cycle.
- spawn_ready_o: 0-cycle, combinational on spawn_lane_i and slot state.
- Spawn commits at the clock edge of the handshake. The new arrow is drawable from the next cycle.
- Back-to-back spawns into the same lane are accepted on consecutive cycles until the lane is full.

## Test plan
- Reset, then spawn lane 2: spawn_ready_o=1 and the spawn is accepted. The next cycle, pixel (82,472) gives arrow_o=4'b0100 one cycle later. Pixels (86,472) and (82,477) give 4'b0000.
- Fill lane 0: four spawns on cycles 1–4, then the fifth spawn_valid_i sees spawn_ready_o=0. After btn_i[0] hits one arrow in the window, ready returns to 1 the next cycle.
- Spawn lane 1, then 216 frame_i pulses (y=38). btn_i[1] gives no hit_o. Frame 217 (y=36): btn_i[1] gives hit_o=4'b0010 next cycle and the slot is cleared.
- Spawn lane 3 with no press: frames 1–223 give no miss. Frame 224 (new_y=22) gives miss_o=4'b1000 one cycle later, and the arrow no longer draws.
- Same-cycle frame_i, btn_i[0] and spawn on lane 0, with the lane 0 arrow at y=30: hit_o[0] pulses, no miss, the new arrow sits at y=470 (unscrolled), and the other lane 0 arrows move by 2.
- Drive rst_ni low mid-frame with 3 live arrows and a pending hit pulse: all outputs drop to 0 immediately and spawn_ready_o=1 after release.

Source files
------------

// File: rtl/arrow_lane_engine.sv
// arrow_lane_engine: per-lane arrow slots with spawn handshake, per-frame
// scroll, hit/miss judging against the target line and a registered
// per-lane pixel coverage mask.
module arrow_lane_engine #(
  parameter int CORDW        = 10,
  parameter int LANES        = 4,
  parameter int SLOTS        = 4,
  parameter int ARROWX_BEGIN = 0,
  parameter int LANE_PITCH   = 40,
  parameter int ARROW_SIZE   = 5,
  parameter int SPAWN_Y      = 470,
  parameter int TARGET_Y     = 30,
  parameter int HIT_WIN      = 6,
  parameter int SPEED        = 2,
  localparam int LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             frame_i,
  input  logic [CORDW-1:0] sx_i,
  input  logic [CORDW-1:0] sy_i,
  input  logic             spawn_valid_i,
  input  logic [LW-1:0]    spawn_lane_i,
  output logic             spawn_ready_o,
  input  logic [LANES-1:0] btn_i,
  output logic [LANES-1:0] hit_o,
  output logic [LANES-1:0] miss_o,
  output logic [LANES-1:0] arrow_o
);

  localparam int SW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW1 = CORDW + 1;

  // Window and miss arithmetic is done one bit wider so sums never wrap.
  localparam logic [CW1-1:0]   WIN_LO  = CW1'(TARGET_Y - HIT_WIN);
  localparam logic [CW1-1:0]   WIN_HI  = CW1'(TARGET_Y + HIT_WIN);
  localparam logic [CW1-1:0]   TGT     = CW1'(TARGET_Y);
  localparam logic [CW1-1:0]   HWIN    = CW1'(HIT_WIN);
  localparam logic [CW1-1:0]   ASIZE   = CW1'(ARROW_SIZE);
  localparam logic [CORDW-1:0] SPD     = CORDW'(SPEED);
  localparam logic [CORDW-1:0] SPAWN_C = CORDW'(SPAWN_Y);

  logic             valid_q     [LANES][SLOTS];
  logic             valid_d     [LANES][SLOTS];
  logic [CORDW-1:0] y_q         [LANES][SLOTS];
  logic [CORDW-1:0] y_d         [LANES][SLOTS];
  logic [LANES-1:0] hit_q, hit_d;
  logic [LANES-1:0] miss_q, miss_d;
  logic [LANES-1:0] arrow_q, arrow_d;

  logic             lane_free   [LANES];
  logic [SW-1:0]    free_idx    [LANES];
  logic             win_found   [LANES];
  logic [SW-1:0]    win_idx     [LANES];
  logic [CORDW-1:0] win_y       [LANES];
  logic [CORDW-1:0] scroll_y    [LANES][SLOTS];
  logic             scroll_miss [LANES][SLOTS];
  logic             spawn_fire;

  // Lowest free slot per lane; ready reflects the requested lane only, so an
  // out-of-range lane number never matches and stays not-ready.
  always_comb begin
    spawn_ready_o = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_free[l] = 1'b0;
      free_idx[l]  = '0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
        if (!valid_q[l][s]) begin
          lane_free[l] = 1'b1;
          free_idx[l]  = SW'(s);
        end
      end
      if (spawn_lane_i == LW'(l)) spawn_ready_o = lane_free[l];
    end
  end

  assign spawn_fire = spawn_valid_i && spawn_ready_o;

  // Judge: in-window slot with the lowest pre-scroll y wins, lowest index on ties.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      win_found[l] = 1'b0;
      win_idx[l]   = '0;
      win_y[l]     = '0;
      for (int s = 0; s < SLOTS; s++) begin
        if (valid_q[l][s] &&
            ({1'b0, y_q[l][s]} >= WIN_LO) && ({1'b0, y_q[l][s]} <= WIN_HI) &&
            (!win_found[l] || (y_q[l][s] < win_y[l]))) begin
          win_found[l] = 1'b1;
          win_idx[l]   = SW'(s);
          win_y[l]     = y_q[l][s];
        end
      end
    end
  end

  // Scrolled position (clamped at 0) and whether it has passed the window.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        scroll_y[l][s]    = (y_q[l][s] < SPD) ? '0 : (y_q[l][s] - SPD);
        scroll_miss[l][s] = (({1'b0, scroll_y[l][s]} + HWIN) < TGT);
      end
    end
  end

  // Slot update: hit beats scroll, and a spawn lands only in a slot that was
  // free before this cycle, so it never collides with a hit or a miss.
  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    hit_d   = '0;
    miss_d  = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (btn_i[l] && win_found[l] && (win_idx[l] == SW'(s))) begin
          valid_d[l][s] = 1'b0;
          y_d[l][s]     = '0;
          hit_d[l]      = 1'b1;
        end else if (frame_i && valid_q[l][s]) begin
          if (scroll_miss[l][s]) begin
            valid_d[l][s] = 1'b0;
            y_d[l][s]     = '0;
            miss_d[l]     = 1'b1;
          end else begin
            y_d[l][s] = scroll_y[l][s];
          end
        end
        if (spawn_fire && (spawn_lane_i == LW'(l)) && (free_idx[l] == SW'(s))) begin
          valid_d[l][s] = 1'b1;
          y_d[l][s]     = SPAWN_C;
        end
      end
    end
  end

  // Coverage of the current pixel by any live arrow, per lane.
  always_comb begin
    arrow_d = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (valid_q[l][s] &&
            ({1'b0, sx_i} >= CW1'(ARROWX_BEGIN + l * LANE_PITCH)) &&
            ({1'b0, sx_i} <= CW1'(ARROWX_BEGIN + l * LANE_PITCH + ARROW_SIZE)) &&
            ({1'b0, sy_i} >= {1'b0, y_q[l][s]}) &&
            ({1'b0, sy_i} <= ({1'b0, y_q[l][s]} + ASIZE))) begin
          arrow_d[l] = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < SLOTS; s++) begin
          valid_q[l][s] <= 1'b0;
          y_q[l][s]     <= '0;
        end
      end
      hit_q   <= '0;
      miss_q  <= '0;
      arrow_q <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      arrow_q <= arrow_d;
    end
  end

  assign hit_o   = hit_q;
  assign miss_o  = miss_q;
  assign arrow_o = arrow_q;

endmodule

// File: tb/tb_arrow_lane_engine.sv
// Bench for arrow_lane_engine: directed stimulus pushes expectations into
// queues; monitors pop and compare when the DUT presents pulses, handshakes
// or probed coverage samples.
module tb_arrow_lane_engine;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       frame_i = 1'b0;
  logic [9:0] sx_i = '0;
  logic [9:0] sy_i = '0;
  logic       spawn_valid_i = 1'b0;
  logic [1:0] spawn_lane_i = '0;
  logic       spawn_ready_o;
  logic [3:0] btn_i = '0;
  logic [3:0] hit_o;
  logic [3:0] miss_o;
  logic [3:0] arrow_o;

  logic probe = 1'b0;
  logic probe_d = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pulse_q[$];
  string      pulse_tag[$];
  logic [3:0] arr_q[$];
  string      arr_tag[$];
  logic       rdy_q[$];
  string      rdy_tag[$];

  arrow_lane_engine dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .frame_i       (frame_i),
    .sx_i          (sx_i),
    .sy_i          (sy_i),
    .spawn_valid_i (spawn_valid_i),
    .spawn_lane_i  (spawn_lane_i),
    .spawn_ready_o (spawn_ready_o),
    .btn_i         (btn_i),
    .hit_o         (hit_o),
    .miss_o        (miss_o),
    .arrow_o       (arrow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitors: pulses, spawn handshake and delayed coverage samples.
  always @(posedge clk) probe_d <= probe;

  always @(negedge clk) begin
    if ((hit_o | miss_o) != '0) begin
      if (pulse_q.size() == 0) check("unexpected_pulse", {hit_o, miss_o}, 8'h00);
      else check(pulse_tag.pop_front(), {hit_o, miss_o}, pulse_q.pop_front());
    end
    if (spawn_valid_i) begin
      if (rdy_q.size() == 0) check("unexpected_spawn", 8'(spawn_ready_o), 8'hff);
      else check(rdy_tag.pop_front(), 8'(spawn_ready_o), 8'(rdy_q.pop_front()));
    end
    if (probe_d) begin
      if (arr_q.size() == 0) check("unexpected_probe", 8'(arrow_o), 8'hff);
      else check(arr_tag.pop_front(), 8'(arrow_o), 8'(arr_q.pop_front()));
    end
  end

  initial forever begin
    @(negedge rst_ni);
    #1;
    check("rst_hit", 8'(hit_o), 8'h00);
    check("rst_miss", 8'(miss_o), 8'h00);
    check("rst_arrow", 8'(arrow_o), 8'h00);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    frame_i       = 1'b0;
    btn_i         = '0;
    spawn_valid_i = 1'b0;
    probe         = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic set_spawn(input int lane, input logic exp_rdy, input string tag);
    spawn_lane_i  = 2'(lane);
    spawn_valid_i = 1'b1;
    rdy_q.push_back(exp_rdy);
    rdy_tag.push_back(tag);
  endtask

  task automatic set_pix(input int x, input int y, input logic [3:0] exp, input string tag);
    sx_i  = 10'(x);
    sy_i  = 10'(y);
    probe = 1'b1;
    arr_q.push_back(exp);
    arr_tag.push_back(tag);
  endtask

  task automatic expect_pulse(input logic [3:0] hit, input logic [3:0] miss, input string tag);
    pulse_q.push_back({hit, miss});
    pulse_tag.push_back(tag);
  endtask

  task automatic run_frames(input int n);
    repeat (n) begin
      frame_i = 1'b1;
      step();
    end
  endtask

  initial begin
    #2;

    // Spawn and draw in lane 2
    do_reset();
    set_spawn(2, 1'b1, "t1_ready");
    set_pix(82, 472, 4'b0000, "t1_spawn_cycle");
    step();
    set_pix(82, 472, 4'b0100, "t1_inside");     step();
    set_pix(86, 472, 4'b0000, "t1_right_of");   step();
    set_pix(82, 477, 4'b0000, "t1_below");      step();
    set_pix(80, 470, 4'b0100, "t1_corner_lo");  step();
    set_pix(85, 475, 4'b0100, "t1_corner_hi");  step();
    set_pix(79, 470, 4'b0000, "t1_left_of");    step();
    drain();

    // Fill lane 0, full backpressure, hit frees a slot next cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_spawn(0, 1'b1, "t2_fill");
      step();
    end
    set_spawn(0, 1'b0, "t2_full");
    step();
    run_frames(220);
    btn_i = 4'b0001;
    set_spawn(0, 1'b0, "t2_full_on_hit_cycle");
    expect_pulse(4'b0001, 4'b0000, "t2_hit");
    step();
    set_spawn(0, 1'b1, "t2_ready_again"); step();
    set_spawn(0, 1'b0, "t2_full_again");  step();
    btn_i = 4'b0001;
    expect_pulse(4'b0001, 4'b0000, "t2_hit2");
    step();
    set_pix(2, 470, 4'b0001, "t2_new_arrow");  step();
    set_pix(2, 30, 4'b0001, "t2_old_arrows");  step();
    drain();

    // Upper window edge: y=38 no hit, y=36 hit
    do_reset();
    set_spawn(1, 1'b1, "t3_ready");
    step();
    run_frames(216);
    btn_i = 4'b0010;
    step();
    set_pix(42, 38, 4'b0010, "t3_still_live"); step();
    run_frames(1);
    btn_i = 4'b0010;
    expect_pulse(4'b0010, 4'b0000, "t3_hit");
    step();
    set_pix(42, 36, 4'b0000, "t3_cleared");    step();
    run_frames(5);
    drain();

    // Miss on frame 224 (new_y=22)
    do_reset();
    set_spawn(3, 1'b1, "t4_ready");
    step();
    run_frames(223);
    set_pix(122, 24, 4'b1000, "t4_at_24");     step();
    expect_pulse(4'b0000, 4'b1000, "t4_miss");
    run_frames(1);
    set_pix(122, 24, 4'b0000, "t4_gone");      step();
    set_pix(122, 2, 4'b0000, "t4_gone_low");   step();
    btn_i = 4'b1000;
    step();
    drain();

    // Same-cycle frame, hit and spawn in lane 0
    do_reset();
    set_spawn(0, 1'b1, "t5_a");
    step();
    run_frames(10);
    set_spawn(0, 1'b1, "t5_b");
    step();
    run_frames(210);
    frame_i = 1'b1;
    btn_i   = 4'b0001;
    set_spawn(0, 1'b1, "t5_c");
    expect_pulse(4'b0001, 4'b0000, "t5_hit_no_miss");
    step();
    set_pix(2, 474, 4'b0001, "t5_new_unscrolled"); step();
    set_pix(2, 469, 4'b0000, "t5_new_not_468");    step();
    set_pix(2, 48, 4'b0001, "t5_other_at_48");     step();
    set_pix(2, 47, 4'b0000, "t5_other_above");     step();
    set_pix(2, 33, 4'b0000, "t5_hit_cleared");     step();
    drain();

    // Asynchronous reset with live arrows and pending hit and coverage
    do_reset();
    set_spawn(0, 1'b1, "t6_a");
    step();
    run_frames(220);
    set_spawn(1, 1'b1, "t6_b"); step();
    set_spawn(2, 1'b1, "t6_c"); step();
    btn_i = 4'b0001;
    sx_i  = 10'd42;
    sy_i  = 10'd472;
    step();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
    set_spawn(0, 1'b1, "t6_ready_after");             step();
    set_pix(42, 472, 4'b0000, "t6_lane1_cleared");    step();
    set_pix(2, 470, 4'b0001, "t6_respawn");           step();
    set_pix(2, 30, 4'b0000, "t6_lane0_old_cleared");  step();
    drain();

    check("pulse_queue_left", 8'(pulse_q.size()), 8'h00);
    check("probe_queue_left", 8'(arr_q.size()), 8'h00);
    check("ready_queue_left", 8'(rdy_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
